// File: rtl/fir_filt_tdm.sv
// Time-multiplexed FIR: CH channels share one coefficient set; one tap per cycle.
// Result TAPS+2 cycles after accept; in_ready low while busy. FIR_SAT_EN enables output clamping.
`timescale 1ns/1ps
module fir_filt_tdm #(
    parameter int SIG_W   = 12,
    parameter int COEF_W  = 18,
    parameter int TAPS    = 16,
    parameter int CH      = 2,
    parameter int ACC_W   = 40,
    parameter int SHIFT_W = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      coef_wr,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]         coef_wdata,
    output logic                      coef_ack,
    output logic [COEF_W-1:0]         coef_rdata,
    input  logic                      shift_wr,
    input  logic [SHIFT_W-1:0]        shift_in,
    output logic [SHIFT_W-1:0]        shift_val,
    input  logic                      in_valid,
    input  logic [CH*SIG_W-1:0]       in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [CH*SIG_W-1:0]       out_data,
    output logic                      overrun
);
    localparam int AW = $clog2(TAPS);
    localparam int PW = SIG_W + COEF_W;
    localparam logic signed [COEF_W-1:0] COEF_MAX = {1'b0, {(COEF_W-1){1'b1}}};

    generate
        if (ACC_W < SIG_W + COEF_W + $clog2(TAPS)) begin : g_acc_chk
            $fatal(1, "fir_filt_tdm: ACC_W too narrow for SIG_W+COEF_W+clog2(TAPS)");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state_q, state_d;

    logic [AW-1:0]              k_q;
    logic signed [SIG_W-1:0]    dly_q [CH][TAPS];
    logic signed [COEF_W-1:0]   coef_q [TAPS];
    logic signed [ACC_W-1:0]    acc_q [CH];
    logic signed [PW-1:0]       prod [CH];
    logic [SHIFT_W-1:0]         shift_q, shift_lat_q;
    logic [COEF_W-1:0]          coef_rdata_q;
    logic                       coef_ack_q, out_valid_q, overrun_q;
    logic [CH*SIG_W-1:0]        out_data_q, res_d;
    logic                       accept, coef_take;

    // The ack cycle blocks re-acceptance while the requester is still holding coef_wr.
    assign accept    = in_valid && (state_q == IDLE) && !flush;
    assign coef_take = coef_wr && (state_q == IDLE) && !coef_ack_q;

    function automatic logic signed [ACC_W-1:0] ashr(input logic signed [ACC_W-1:0] a,
                                                     input logic [SHIFT_W-1:0] s);
        if (int'(s) >= ACC_W) return {ACC_W{a[ACC_W-1]}};
        return a >>> s;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MAC;
            MAC:     if (k_q == AW'(TAPS - 1)) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            prod[c] = PW'(dly_q[c][k_q]) * PW'(coef_q[k_q]);
        end
    end

`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0] sh;
`endif

    always_comb begin
        res_d = '0;
`ifdef FIR_SAT_EN
        sh = '0;
`endif
        for (int c = 0; c < CH; c++) begin
`ifdef FIR_SAT_EN
            sh = ashr(acc_q[c], shift_lat_q);
            if ((&sh[ACC_W-1:SIG_W-1]) || !(|sh[ACC_W-1:SIG_W-1]))
                res_d[c*SIG_W +: SIG_W] = sh[SIG_W-1:0];
            else
                res_d[c*SIG_W +: SIG_W] = sh[ACC_W-1] ? {1'b1, {(SIG_W-1){1'b0}}}
                                                      : {1'b0, {(SIG_W-1){1'b1}}};
`else
            res_d[c*SIG_W +: SIG_W] = SIG_W'(ashr(acc_q[c], shift_lat_q));
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q          <= '0;
            shift_q      <= SHIFT_W'(COEF_W - 1);
            shift_lat_q  <= '0;
            coef_rdata_q <= '0;
            coef_ack_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            out_data_q   <= '0;
            for (int t = 0; t < TAPS; t++) coef_q[t] <= '0;
            coef_q[0] <= COEF_MAX;
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= '0;
                for (int t = 0; t < TAPS; t++) dly_q[c][t] <= '0;
            end
        end else begin
            if (shift_wr) shift_q <= shift_in;
            if (coef_take) coef_q[coef_addr] <= coef_wdata;
            coef_ack_q   <= coef_take;
            coef_rdata_q <= coef_q[coef_addr];

            if (flush) begin
                k_q         <= '0;
                out_valid_q <= 1'b0;
                overrun_q   <= 1'b0;
                out_data_q  <= '0;
                for (int c = 0; c < CH; c++) begin
                    acc_q[c] <= '0;
                    for (int t = 0; t < TAPS; t++) dly_q[c][t] <= '0;
                end
            end else begin
                out_valid_q <= 1'b0;
                if (in_valid && state_q != IDLE) overrun_q <= 1'b1;
                case (state_q)
                    IDLE: if (in_valid) begin
                        k_q         <= '0;
                        shift_lat_q <= shift_q;
                        for (int c = 0; c < CH; c++) begin
                            acc_q[c] <= '0;
                            for (int t = TAPS - 1; t > 0; t--) dly_q[c][t] <= dly_q[c][t-1];
                            dly_q[c][0] <= in_data[c*SIG_W +: SIG_W];
                        end
                    end
                    MAC: begin
                        k_q <= k_q + 1'b1;
                        for (int c = 0; c < CH; c++) acc_q[c] <= acc_q[c] + ACC_W'(prod[c]);
                    end
                    OUT: begin
                        out_data_q  <= res_d;
                        out_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign coef_ack   = coef_ack_q;
    assign coef_rdata = coef_rdata_q;
    assign shift_val  = shift_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_fir_filt_tdm.sv
// Directed bench for fir_filt_tdm: vector table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_fir_filt_tdm;
    localparam int SIG_W = 12, COEF_W = 18, TAPS = 16, CH = 2, ACC_W = 40, SHIFT_W = 6, AW = 4;

    logic                 clk = 1'b0, rst_n = 1'b0, flush = 1'b0, coef_wr = 1'b0;
    logic [AW-1:0]        coef_addr = '0;
    logic [COEF_W-1:0]    coef_wdata = '0, coef_rdata;
    logic                 coef_ack, shift_wr = 1'b0;
    logic [SHIFT_W-1:0]   shift_in = '0, shift_val;
    logic                 in_valid = 1'b0, in_ready, out_valid, overrun;
    logic [CH*SIG_W-1:0]  in_data = '0, out_data;

    fir_filt_tdm #(.SIG_W(SIG_W), .COEF_W(COEF_W), .TAPS(TAPS), .CH(CH), .ACC_W(ACC_W),
                   .SHIFT_W(SHIFT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .coef_wr(coef_wr), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .coef_ack(coef_ack), .coef_rdata(coef_rdata),
        .shift_wr(shift_wr), .shift_in(shift_in), .shift_val(shift_val),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .overrun(overrun));

    always #5 clk = ~clk;

    typedef struct { int a; int b; int ea; int eb; } vec_t;
    vec_t tbl [5];
    int   n_vec = 0, n_err = 0;
    int   lat, oa, ob, ov_i, ack_i, n_ack, seen;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [SIG_W-1:0] s12(input int v);
        return v[SIG_W-1:0];
    endfunction

    function automatic int sa();
        return int'($signed(out_data[SIG_W-1:0]));
    endfunction

    function automatic int sb();
        return int'($signed(out_data[2*SIG_W-1:SIG_W]));
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is seen (lat = cycles).
    task automatic send(input int a, input int b, output int l, output int ra, output int rb);
        l = 0; ra = 0; rb = 0;
        in_data  = {s12(b), s12(a)};
        in_valid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin in_valid = 1'b0; coef_wr = 1'b0; end
            if (out_valid) begin l = i; ra = sa(); rb = sb(); break; end
        end
    endtask

    task automatic coef_write(input int addr, input int val);
        int got;
        got = 0;
        coef_addr = AW'(addr); coef_wdata = COEF_W'(val); coef_wr = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (coef_ack) begin got = 1; break; end
        end
        coef_wr = 1'b0;
        chk("coef_ack_seen", got, 1);
    endtask

    task automatic shift_set(input int v);
        shift_in = SHIFT_W'(v); shift_wr = 1'b1;
        @(negedge clk);
        shift_wr = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{100, -100, 99, -100};
        tbl[1] = '{2047, -2048, 2046, -2048};
        tbl[2] = '{0, 1, 0, 0};
        tbl[3] = '{-1, 5, -1, 4};
        tbl[4] = '{1, -1, 0, -1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_coef_ack", int'(coef_ack), 0);
        chk("rst_coef_rdata", int'(coef_rdata), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_shift_val", int'(shift_val), 17);
        rst_n = 1'b1;
        @(negedge clk);
        chk("default_coef0", int'(coef_rdata), 131071);

        // Default coefficients, shift 17: back-to-back samples
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].a, tbl[i].b, lat, oa, ob);
            chk("tbl_latency", lat, 18);
            chk("tbl_a", oa, tbl[i].ea);
            chk("tbl_b", ob, tbl[i].eb);
        end

        // Second in_valid 5 cycles in is dropped and flags overrun
        lat = 0;
        in_data = {s12(-100), s12(100)}; in_valid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) in_valid = 1'b0;
            if (i == 5) begin in_valid = 1'b1; in_data = {s12(500), s12(500)}; end
            if (i == 6) in_valid = 1'b0;
            if (out_valid) begin lat = i; oa = sa(); ob = sb(); break; end
        end
        chk("ovr_latency", lat, 18);
        chk("ovr_a", oa, 99);
        chk("ovr_b", ob, -100);
        chk("ovr_flag", int'(overrun), 1);
        flush_pulse();
        chk("flush_overrun", int'(overrun), 0);
        chk("flush_idle", int'(in_ready), 1);
        chk("flush_out_data", int'(out_data), 0);

        // Flush mid-MAC together with in_valid: flush wins, no overrun, no result
        in_data = {s12(-100), s12(100)}; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_in_ready", int'(in_ready), 0);
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        chk("flush_mac_idle", int'(in_ready), 1);
        chk("flush_mac_overrun", int'(overrun), 0);
        seen = 0;
        repeat (25) begin @(negedge clk); if (out_valid) seen++; end
        chk("flush_no_out_valid", seen, 0);

        // Flush + in_valid in IDLE: sample dropped
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_in_ready", int'(in_ready), 1);
        chk("flush_idle_overrun", int'(overrun), 0);

        // coef_wr held from MAC cycle 3; shift change mid-MAC
        ov_i = 0; ack_i = 0; n_ack = 0;
        in_data = {s12(-100), s12(100)}; in_valid = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            if (i == 1) in_valid = 1'b0;
            if (i == 4) begin coef_addr = '0; coef_wdata = COEF_W'(65536); coef_wr = 1'b1; end
            if (i == 6) begin shift_in = SHIFT_W'(16); shift_wr = 1'b1; end
            if (i == 7) shift_wr = 1'b0;
            if (out_valid) begin ov_i = i; oa = sa(); ob = sb(); end
            if (coef_ack) begin n_ack++; if (ack_i == 0) ack_i = i; coef_wr = 1'b0; end
        end
        chk("held_out_cycle", ov_i, 18);
        chk("held_ack_cycle", ack_i, 19);
        chk("held_ack_count", n_ack, 1);
        chk("held_old_coef_a", oa, 99);
        chk("held_old_coef_b", ob, -100);
        chk("held_shift_val", int'(shift_val), 16);
        chk("held_rdata", int'(coef_rdata), 65536);
        send(100, -100, lat, oa, ob);
        chk("new_coef_a", oa, 100);
        chk("new_coef_b", ob, -100);

        // Impulse response with coeffs k+1, shift 0
        flush_pulse();
        for (int k = 0; k < TAPS; k++) coef_write(k, k + 1);
        shift_set(0);
        chk("imp_shift_val", int'(shift_val), 0);
        chk("imp_rdata15", int'(coef_rdata), 16);
        for (int n = 0; n < 18; n++) begin
            send((n == 0) ? 1 : 0, (n == 1) ? -2 : 0, lat, oa, ob);
            chk("imp_a", oa, (n < 16) ? n + 1 : 0);
            chk("imp_b", ob, (n >= 1 && n <= 16) ? -2 * n : 0);
        end

        // Single full-scale tap, shift 0: saturate or wrap
        flush_pulse();
        coef_write(0, 131071);
        for (int k = 1; k < TAPS; k++) coef_write(k, 0);
        send(2047, -2048, lat, oa, ob);
`ifdef FIR_SAT_EN
        chk("sat_a", oa, 2047);
`else
        chk("wrap_a", oa, -2047);
`endif
        chk("big_neg_b", ob, -2048);

        // Shift at and beyond the accumulator width
        shift_set(39);
        send(2047, -2048, lat, oa, ob);
        chk("sh39_a", oa, 0);
        chk("sh39_b", ob, -1);
        shift_set(40);
        send(2047, -2048, lat, oa, ob);
        chk("sh40_a", oa, 0);
        chk("sh40_b", ob, -1);
        shift_set(63);
        send(2047, -2048, lat, oa, ob);
        chk("sh63_a", oa, 0);
        chk("sh63_b", ob, -1);

        // Coefficient write and sample in the same IDLE cycle
        shift_set(17);
        coef_addr = '0; coef_wdata = COEF_W'(65536); coef_wr = 1'b1;
        send(100, -100, lat, oa, ob);
        chk("same_cycle_a", oa, 50);
        chk("same_cycle_b", ob, -50);
        chk("same_cycle_rdata", int'(coef_rdata), 65536);

        // Reset during MAC cycle 8
        coef_write(1, 77);
        @(negedge clk);
        chk("rdata_before_rst", int'(coef_rdata), 77);
        in_data = {s12(-100), s12(100)}; in_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) in_valid = 1'b0;
            if (i == 5) in_valid = 1'b1;
            if (i == 6) in_valid = 1'b0;
        end
        chk("ovr_before_rst", int'(overrun), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mac_out_data", int'(out_data), 0);
        chk("rst_mac_out_valid", int'(out_valid), 0);
        chk("rst_mac_overrun", int'(overrun), 0);
        chk("rst_mac_rdata", int'(coef_rdata), 0);
        chk("rst_mac_idle", int'(in_ready), 1);
        chk("rst_mac_shift", int'(shift_val), 17);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin @(negedge clk); if (out_valid) seen++; end
        chk("rst_mac_no_out_valid", seen, 0);
        chk("rst_coef1_default", int'(coef_rdata), 0);
        coef_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_coef0_default", int'(coef_rdata), 131071);
        chk("rst_mac_out_data_after", int'(out_data), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
